multdiv_ctrl: RTL

Execute-stage controller that sequences the shared multicycle multiplier/divider for the simple processor. It detects R-type `mul`/`div` from decoded instruction fields and latches the operands. It issues a one-cycle start pulse, stalls the pipeline until the unit reports ready or a watchdog expires, then drives one write-back cycle. Write-back goes to `rd`, or to `$r30` (rstatus) with code 4/5 on exception.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/cycle_watchdog.sv | 28 ++
 rtl/multdiv_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants and the multdiv controller state encoding.
package proc_pkg;

   localparam logic [4:0] OP_ALU      = 5'b00000;
   localparam logic [4:0] ALU_MUL     = 5'b00110;
   localparam logic [4:0] ALU_DIV     = 5'b00111;
   localparam logic [4:0] RSTATUS_REG = 5'd30;

   // rstatus codes; add/addi/sub are raised by the ALU path, not here
   localparam logic [31:0] RS_ADD  = 32'd1;
   localparam logic [31:0] RS_ADDI = 32'd2;
   localparam logic [31:0] RS_SUB  = 32'd3;
   localparam logic [31:0] RS_MUL  = 32'd4;
   localparam logic [31:0] RS_DIV  = 32'd5;

   typedef enum logic [1:0] {
      MDC_IDLE,
      MDC_START,
      MDC_WAIT,
      MDC_WB
   } mdc_state_t;

endpackage

// File: rtl/cycle_watchdog.sv
// Saturating cycle counter; terminal flags the last allowed wait cycle.
module cycle_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !terminal)
         count <= count + CW'(1);
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the shared multiplier/divider: start pulse,
// pipeline stall until ready or watchdog expiry, then one write-back cycle.
module multdiv_ctrl
   import proc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  opcode,
   input  logic [4:0]  alu_op,
   input  logic [4:0]  rd,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_operand_a,
   output logic [31:0] md_operand_b,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_result_rdy,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        timeout_err
);

   mdc_state_t  state, state_nxt;
   logic        detect;
   logic        wd_terminal;
   logic        op_div;
   logic [4:0]  rd_q;
   logic [31:0] result_q;
   logic        exc_q;

   assign detect = issue_valid && (opcode == OP_ALU) &&
                   ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

   cycle_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock    (clock),
      .reset    (reset),
      .clear    (state == MDC_START),
      .enable   (state == MDC_WAIT),
      .terminal (wd_terminal)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= MDC_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         md_operand_a <= '0;
         md_operand_b <= '0;
         rd_q         <= '0;
         op_div       <= 1'b0;
         result_q     <= '0;
         exc_q        <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         case (state)
            MDC_IDLE: begin
               if (detect) begin
                  md_operand_a <= operand_a;
                  md_operand_b <= operand_b;
                  rd_q         <= rd;
                  op_div       <= (alu_op == ALU_DIV);
               end
            end
            MDC_WAIT: begin
               // ready takes priority over a watchdog expiring in the same cycle
               if (md_result_rdy) begin
                  result_q <= md_result;
                  exc_q    <= md_exception;
               end else if (wd_terminal) begin
                  exc_q       <= 1'b1;
                  timeout_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      stall        = 1'b0;
      md_ctrl_mult = 1'b0;
      md_ctrl_div  = 1'b0;
      wb_en        = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      case (state)
         MDC_IDLE: begin
            stall = detect;
            if (detect)
               state_nxt = MDC_START;
         end
         MDC_START: begin
            stall        = 1'b1;
            md_ctrl_mult = !op_div;
            md_ctrl_div  = op_div;
            state_nxt    = MDC_WAIT;
         end
         MDC_WAIT: begin
            stall = 1'b1;
            if (md_result_rdy || wd_terminal)
               state_nxt = MDC_WB;
         end
         MDC_WB: begin
            state_nxt = MDC_IDLE;
            if (exc_q) begin
               wb_en   = 1'b1;
               wb_rd   = RSTATUS_REG;
               wb_data = op_div ? RS_DIV : RS_MUL;
            end else if (rd_q != 5'd0) begin
               wb_en   = 1'b1;
               wb_rd   = rd_q;
               wb_data = result_q;
            end
         end
         default: state_nxt = MDC_IDLE;
      endcase
   end

endmodule
